// File: rtl/btn_pulse_gen.sv
// Multi-channel button conditioner: 2-flop synchroniser, ms-tick debounce,
// selectable edge pulse and optional auto-repeat while held, per channel.
module btn_pulse_gen #(
  parameter int N               = 4,
  parameter int DEBOUNCE_MS     = 10,
  parameter int EDGE_MODE       = 0,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick_1ms,
  input  logic [N-1:0] btn_in,
  input  logic [N-1:0] repeat_en,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] load_out,
  output logic [N-1:0] held
);
  localparam int DW   = $clog2(DEBOUNCE_MS + 1);
  localparam int RMAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic RISE_EN = (EDGE_MODE == 0) || (EDGE_MODE == 2);
  localparam logic FALL_EN = (EDGE_MODE == 1) || (EDGE_MODE == 2);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_MS - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY_MS - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE_MS - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_e;

  logic [N-1:0] meta_q, meta_d, sync_q, sync_d;

  always_comb begin
    meta_d = btn_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          lvl_q, lvl_d, prev_q, prev_d, load_q, load_d;
    rpt_state_e    st_q, st_d;
    logic          rise_c, fall_c, rep_fire;

    always_comb begin
      dcnt_d = dcnt_q;
      lvl_d  = lvl_q;
      prev_d = lvl_q;
      if (sync_q[i] == lvl_q) begin
        dcnt_d = '0;
      end else if (tick_1ms) begin
        if (dcnt_q == DB_LAST) begin
          lvl_d  = ~lvl_q;
          dcnt_d = '0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      // Commits are taken from lvl_d so an abort lands on the same clk as the release commit
      rise_c = lvl_d & ~lvl_q;
      fall_c = ~lvl_d & lvl_q;

      st_d     = st_q;
      rcnt_d   = rcnt_q;
      rep_fire = 1'b0;
      case (st_q)
        IDLE: begin
          if (rise_c && repeat_en[i]) begin
            st_d   = DELAY;
            rcnt_d = '0;
          end
        end
        DELAY: begin
          if (fall_c || !repeat_en[i]) begin
            st_d   = IDLE;
            rcnt_d = '0;
          end else if (tick_1ms) begin
            if (rcnt_q == DELAY_LAST) begin
              rep_fire = 1'b1;
              st_d     = REPEAT;
              rcnt_d   = '0;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
        end
        REPEAT: begin
          if (fall_c || !repeat_en[i]) begin
            st_d   = IDLE;
            rcnt_d = '0;
          end else if (tick_1ms) begin
            if (rcnt_q == RATE_LAST) begin
              rep_fire = 1'b1;
              rcnt_d   = '0;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
        end
        default: begin
          st_d   = IDLE;
          rcnt_d = '0;
        end
      endcase

      load_d = (RISE_EN & lvl_q & ~prev_q) | (FALL_EN & ~lvl_q & prev_q) | rep_fire;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        dcnt_q <= '0;
        rcnt_q <= '0;
        lvl_q  <= 1'b0;
        prev_q <= 1'b0;
        load_q <= 1'b0;
        st_q   <= IDLE;
      end else begin
        dcnt_q <= dcnt_d;
        rcnt_q <= rcnt_d;
        lvl_q  <= lvl_d;
        prev_q <= prev_d;
        load_q <= load_d;
        st_q   <= st_d;
      end
    end

    assign btn_level[i] = lvl_q;
    assign load_out[i]  = load_q;
    assign held[i]      = (st_q == REPEAT);
  end

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Bench for btn_pulse_gen: directed scenarios with literal expectations plus
// randomized stimulus checked every cycle against a tick-arithmetic model.
module tb_btn_pulse_gen;
  localparam int DB = 3;
  localparam int RD = 5;
  localparam int RR = 2;

  logic       clk, rst, tick_1ms;
  logic [1:0] btn_in, repeat_en;
  logic [1:0] lvl0, ld0, hd0, lvl2, ld2, hd2;

  btn_pulse_gen #(.N(2), .DEBOUNCE_MS(DB), .EDGE_MODE(0), .REPEAT_DELAY_MS(RD), .REPEAT_RATE_MS(RR)) dut_m0 (
    .clk(clk), .rst(rst), .tick_1ms(tick_1ms), .btn_in(btn_in), .repeat_en(repeat_en),
    .btn_level(lvl0), .load_out(ld0), .held(hd0));

  btn_pulse_gen #(.N(2), .DEBOUNCE_MS(DB), .EDGE_MODE(2), .REPEAT_DELAY_MS(RD), .REPEAT_RATE_MS(RR)) dut_m2 (
    .clk(clk), .rst(rst), .tick_1ms(tick_1ms), .btn_in(btn_in), .repeat_en(repeat_en),
    .btn_level(lvl2), .load_out(ld2), .held(hd2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: stable level flips after DB disagreeing ticks; repeat
  // pulses fire at RD ticks after the press commit and every RR ticks after.
  bit         started = 1'b0;
  logic [1:0] m_s1, m_s2, m_lvl, m_prev, m_act, m_load0, m_load2, m_held;
  int         m_run [2];
  int         m_tsp [2];

  always @(posedge clk) begin : model
    int   run_n, tsp_n;
    logic nl, rise, fall, rep, act_n;
    if (rst) begin
      started <= 1'b1;
      m_s1 <= '0; m_s2 <= '0; m_lvl <= '0; m_prev <= '0;
      m_act <= '0; m_load0 <= '0; m_load2 <= '0; m_held <= '0;
      for (int c = 0; c < 2; c++) begin
        m_run[c] <= 0;
        m_tsp[c] <= 0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        run_n = (m_s2[c] == m_lvl[c]) ? 0 : m_run[c] + (tick_1ms ? 1 : 0);
        nl = m_lvl[c];
        if (run_n == DB) begin
          nl    = ~nl;
          run_n = 0;
        end
        rise  = nl & ~m_lvl[c];
        fall  = ~nl & m_lvl[c];
        act_n = m_act[c];
        tsp_n = m_tsp[c];
        rep   = 1'b0;
        if (m_act[c]) begin
          if (fall || !repeat_en[c]) act_n = 1'b0;
          else if (tick_1ms) begin
            tsp_n++;
            rep = (tsp_n == RD) || (tsp_n > RD && (tsp_n - RD) % RR == 0);
          end
        end else if (rise && repeat_en[c]) begin
          act_n = 1'b1;
          tsp_n = 0;
        end
        m_load0[c] <= (m_lvl[c] & ~m_prev[c]) | rep;
        m_load2[c] <= (m_lvl[c] ^ m_prev[c]) | rep;
        m_held[c]  <= act_n && (tsp_n >= RD);
        m_act[c]   <= act_n;
        m_tsp[c]   <= tsp_n;
        m_run[c]   <= run_n;
        m_prev[c]  <= m_lvl[c];
        m_lvl[c]   <= nl;
        m_s2[c]    <= m_s1[c];
        m_s1[c]    <= btn_in[c];
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("level_m0", 32'(lvl0), 32'(m_lvl));
      check("load_m0",  32'(ld0),  32'(m_load0));
      check("held_m0",  32'(hd0),  32'(m_held));
      check("level_m2", 32'(lvl2), 32'(m_lvl));
      check("load_m2",  32'(ld2),  32'(m_load2));
      check("held_m2",  32'(hd2),  32'(m_held));
    end
  end

  // Stimulus driver and channel-0 observers
  int   tph = 0;
  bit   rand_tick = 1'b0;
  logic p_ld0 = 1'b0, p_ld2 = 1'b0;
  int   ob_ticks, ob_rise_tick, ob_rise_cyc, ob_ld_cyc, ob_ld0_n, ob_ld2_n;
  int   ob_width_bad, ob_held_rise, ob_held_seen, ob_lvl_hi_seen, cyc;
  int   ob_offs [$];

  task automatic obs_clear();
    ob_ticks = 0; ob_rise_tick = -1; ob_rise_cyc = -1; ob_ld_cyc = -1;
    ob_ld0_n = 0; ob_ld2_n = 0; ob_width_bad = 0; ob_held_rise = -1;
    ob_held_seen = 0; ob_lvl_hi_seen = 0;
    ob_offs.delete();
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (tick_1ms) ob_ticks++;
    if (lvl0[0] && ob_rise_tick < 0) begin
      ob_rise_tick = ob_ticks;
      ob_rise_cyc  = cyc;
    end
    if (lvl0[0]) ob_lvl_hi_seen = 1;
    if (ld0[0]) begin
      ob_ld0_n++;
      if (ob_ld_cyc < 0) ob_ld_cyc = cyc;
      ob_offs.push_back((ob_rise_tick >= 0) ? ob_ticks - ob_rise_tick : -100);
      if (p_ld0) ob_width_bad++;
    end
    if (ld2[0]) begin
      ob_ld2_n++;
      if (p_ld2) ob_width_bad++;
    end
    p_ld0 = ld0[0];
    p_ld2 = ld2[0];
    if (hd0[0] && ob_held_rise < 0) ob_held_rise = ob_ticks - ob_rise_tick;
    if (hd0[0]) ob_held_seen = 1;
    if (rand_tick) begin
      tick_1ms = !tick_1ms && ($urandom_range(3) == 0);
    end else begin
      tick_1ms = (tph == 9);
      tph = (tph + 1) % 10;
    end
  endtask

  task automatic run_ticks(input int n);
    repeat (n * 10) step();
  endtask

  task automatic align();
    for (int k = 0; k < 30; k++) begin
      step();
      if (ob_ticks > 0 && tph == 1) break;
    end
    obs_clear();
  endtask

  int t4_exp [6] = '{0, 5, 7, 9, 11, 13};

  initial begin
    rst = 1'b1; tick_1ms = 1'b0; btn_in = '0; repeat_en = '0; cyc = 0;
    obs_clear();
    repeat (3) step();
    check("rst_level", 32'(lvl0), 0);
    check("rst_load",  32'(ld0 | ld2), 0);
    check("rst_held",  32'(hd0 | hd2), 0);
    rst = 1'b0;
    run_ticks(2);

    // 1: clean press, no repeat
    align();
    btn_in = 2'b01;
    run_ticks(5);
    check("t1_commit_tick", ob_rise_tick, 3);
    check("t1_load_lag", ob_ld_cyc - ob_rise_cyc, 1);
    check("t1_pulses", ob_ld0_n, 1);
    check("t1_width", ob_width_bad, 0);
    check("t1_held", ob_held_seen, 0);
    check("t1_level", 32'(lvl0[0]), 1);
    btn_in = 2'b00;
    run_ticks(6);

    // 2: bounce shorter than the debounce window
    align();
    for (int r = 0; r < 3; r++) begin
      btn_in = 2'b01;
      repeat (20) step();
      btn_in = 2'b00;
      repeat (20) step();
    end
    check("t2_level_seen", ob_lvl_hi_seen, 0);
    check("t2_pulses_m0", ob_ld0_n, 0);
    check("t2_pulses_m2", ob_ld2_n, 0);

    // 3: press and release, both-edge instance
    align();
    btn_in = 2'b01;
    run_ticks(13);
    btn_in = 2'b00;
    run_ticks(6);
    check("t3_pulses_m2", ob_ld2_n, 2);
    check("t3_pulses_m0", ob_ld0_n, 1);
    check("t3_width", ob_width_bad, 0);

    // 4: auto-repeat while held
    align();
    repeat_en = 2'b01;
    btn_in = 2'b01;
    run_ticks(15);
    btn_in = 2'b00;
    run_ticks(6);
    check("t4_npulse", ob_offs.size(), 6);
    for (int i = 0; i < 6 && i < ob_offs.size(); i++)
      check($sformatf("t4_pulse%0d", i), ob_offs[i], t4_exp[i]);
    check("t4_held_rise", ob_held_rise, 5);
    check("t4_held_end", 32'(hd0[0]), 0);

    // 5: repeat_en dropped while repeating
    align();
    btn_in = 2'b01;
    for (int k = 0; k < 300; k++) begin
      if (ob_rise_tick >= 0 && ob_ticks == ob_rise_tick + 6) break;
      step();
    end
    check("t5_reached", ob_ticks - ob_rise_tick, 6);
    repeat_en = 2'b00;
    run_ticks(4);
    check("t5_npulse", ob_offs.size(), 2);
    if (ob_offs.size() >= 2) check("t5_pulse1", ob_offs[1], 5);
    check("t5_held", 32'(hd0[0]), 0);
    check("t5_level", 32'(lvl0[0]), 1);
    btn_in = 2'b00;
    run_ticks(6);

    // 6: reset mid-repeat coincident with a tick, second channel active too
    align();
    repeat_en = 2'b11;
    btn_in = 2'b01;
    run_ticks(1);
    btn_in = 2'b11;
    run_ticks(9);
    check("t6_held_pre", 32'(hd0), 3);
    for (int k = 0; k < 30; k++) begin
      step();
      if (tick_1ms) break;
    end
    check("t6_tick_coincident", 32'(tick_1ms), 1);
    rst = 1'b1;
    step();
    check("t6_rst_level", 32'(lvl0 | lvl2), 0);
    check("t6_rst_load", 32'(ld0 | ld2), 0);
    check("t6_rst_held", 32'(hd0 | hd2), 0);
    rst = 1'b0;
    obs_clear();
    repeat (60) step();
    check("t6_recommit_tick", ob_rise_tick, 3);
    check("t6_pulses", ob_ld0_n, 1);
    btn_in = 2'b00;
    repeat_en = 2'b00;
    run_ticks(6);

    // Randomized phase with irregular ticks, random bounces and resets
    rand_tick = 1'b1;
    for (int k = 0; k < 300; k++) begin
      int dur;
      for (int c = 0; c < 2; c++)
        if ($urandom_range(1) == 0) btn_in[c] = ~btn_in[c];
      if ($urandom_range(7) == 0) repeat_en[$urandom_range(1)] ^= 1'b1;
      rst = ($urandom_range(60) == 0);
      dur = ($urandom_range(1) == 0) ? $urandom_range(6, 1) : $urandom_range(80, 8);
      repeat (dur) begin
        step();
        rst = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
